esm_issue_retire: RTL and testbench

- Consumer side of the ESM dependency table. The dependency analyser writes per-entry dependency rows; this block reads them.
- Tracks each instruction-buffer entry through FREE, WAITING and ISSUED states.
- Selects dependency-free entries and offers them to the execution unit over a valid/ready handshake.
- On completion, frees the entry and clears its column in every row, waking its dependents.

---
 rtl/esm_issue_retire.sv | 147 ++++++++++++++
 tb/tb_esm_issue_retire.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_retire.sv
// rtl/esm_issue_retire.sv - ESM dependency-table consumer: tracks slots, issues ready entries, retires completions.
// Optional round-robin pick enabled by defining ESM_ROUND_ROBIN_EN; default is fixed lowest-index priority.
module esm_issue_retire #(
   parameter int bs      = 16,
   parameter int bs_bits = $clog2(bs)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_valid,
   input  logic [bs_bits-1:0] alloc_index,
   input  logic [bs-1:0]      alloc_deps,
   output logic               alloc_err,
   output logic               issue_valid,
   output logic [bs_bits-1:0] issue_index,
   input  logic               issue_ready,
   input  logic               done_valid,
   input  logic [bs_bits-1:0] done_index,
   output logic               done_err,
   output logic [bs_bits:0]   occupancy
);

   localparam logic [1:0] S_FREE   = 2'b00;
   localparam logic [1:0] S_WAIT   = 2'b01;
   localparam logic [1:0] S_ISSUED = 2'b10;

   logic [1:0]         state_q [bs];
   logic [1:0]         state_d [bs];
   logic [bs-1:0]      row_q   [bs];
   logic [bs-1:0]      row_d   [bs];
   logic               issue_valid_q, issue_valid_d;
   logic [bs_bits-1:0] issue_index_q, issue_index_d;
   logic               alloc_err_q, alloc_err_d;
   logic               done_err_q, done_err_d;
   logic [bs_bits:0]   occ_q, occ_d;

   logic [bs-1:0]      eligible;
   logic               any_elig;
   logic [bs_bits-1:0] pick;
   logic               done_ok, alloc_ok, load;
   logic [bs-1:0]      done_mask;
`ifdef ESM_ROUND_ROBIN_EN
   logic [bs_bits-1:0] last_q, last_d;
   logic               found;
   int                 j;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < bs; k++) begin
            state_q[k] <= S_FREE;
            row_q[k]   <= '1;
         end
         issue_valid_q <= 1'b0;
         issue_index_q <= '0;
         alloc_err_q   <= 1'b0;
         done_err_q    <= 1'b0;
         occ_q         <= '0;
`ifdef ESM_ROUND_ROBIN_EN
         last_q        <= bs_bits'(bs - 1);
`endif
      end else begin
         for (int k = 0; k < bs; k++) begin
            state_q[k] <= state_d[k];
            row_q[k]   <= row_d[k];
         end
         issue_valid_q <= issue_valid_d;
         issue_index_q <= issue_index_d;
         alloc_err_q   <= alloc_err_d;
         done_err_q    <= done_err_d;
         occ_q         <= occ_d;
`ifdef ESM_ROUND_ROBIN_EN
         last_q        <= last_d;
`endif
      end
   end

   always_comb begin
      for (int k = 0; k < bs; k++) begin
         eligible[k] = (state_q[k] == S_WAIT) && (row_q[k] == '0);
      end
      any_elig = |eligible;
      pick     = '0;
`ifdef ESM_ROUND_ROBIN_EN
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < bs; i++) begin
         j = (int'(last_q) + 1 + i) % bs;
         if (!found && eligible[j[bs_bits-1:0]]) begin
            found = 1'b1;
            pick  = j[bs_bits-1:0];
         end
      end
`else
      for (int i = bs - 1; i >= 0; i--) begin
         if (eligible[i]) pick = bs_bits'(i);
      end
`endif

      // A done on the slot being allocated frees it in time for the alloc.
      done_ok   = done_valid && (state_q[done_index] == S_ISSUED);
      alloc_ok  = alloc_valid && ((state_q[alloc_index] == S_FREE) ||
                                  (done_ok && (done_index == alloc_index)));
      load      = !issue_valid_q || issue_ready;
      done_mask = done_ok ? (bs'(1) << done_index) : '0;

      for (int k = 0; k < bs; k++) begin
         state_d[k] = state_q[k];
         row_d[k]   = row_q[k] & ~done_mask;
      end
      issue_valid_d = issue_valid_q;
      issue_index_d = issue_index_q;
`ifdef ESM_ROUND_ROBIN_EN
      last_d = last_q;
`endif

      if (done_ok) state_d[done_index] = S_FREE;
      if (load) begin
         issue_valid_d = any_elig;
         issue_index_d = pick;
         if (any_elig) begin
            state_d[pick] = S_ISSUED;
`ifdef ESM_ROUND_ROBIN_EN
            last_d = pick;
`endif
         end
      end
      if (alloc_ok) begin
         state_d[alloc_index] = S_WAIT;
         row_d[alloc_index]   = alloc_deps & ~done_mask & ~(bs'(1) << alloc_index);
      end

      alloc_err_d = alloc_valid && !alloc_ok;
      done_err_d  = done_valid && !done_ok;
      occ_d       = occ_q;
      if (alloc_ok && !done_ok) occ_d = occ_q + (bs_bits + 1)'(1);
      if (!alloc_ok && done_ok) occ_d = occ_q - (bs_bits + 1)'(1);
   end

   always_comb begin
      issue_valid = issue_valid_q;
      issue_index = issue_index_q;
      alloc_err   = alloc_err_q;
      done_err    = done_err_q;
      occupancy   = occ_q;
   end

endmodule

// File: tb/tb_esm_issue_retire.sv
// tb/tb_esm_issue_retire.sv - scoreboard bench for esm_issue_retire against a slot-level reference model.
// Honours ESM_ROUND_ROBIN_EN so the model pick order matches the build.
module tb_esm_issue_retire;
   localparam int BS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_valid = 1'b0;
   logic [3:0]  alloc_index = '0;
   logic [15:0] alloc_deps = '0;
   logic        alloc_err;
   logic        issue_valid;
   logic [3:0]  issue_index;
   logic        issue_ready = 1'b0;
   logic        done_valid = 1'b0;
   logic [3:0]  done_index = '0;
   logic        done_err;
   logic [4:0]  occupancy;

   always #5 clk = ~clk;

   esm_issue_retire dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_index(alloc_index), .alloc_deps(alloc_deps),
      .alloc_err(alloc_err),
      .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
      .done_valid(done_valid), .done_index(done_index), .done_err(done_err),
      .occupancy(occupancy)
   );

   typedef struct {
      bit iv;
      int ii;
      bit aerr;
      bit derr;
      int occ;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: 0 = free, 1 = waiting, 2 = issued; dep[k] = set of slots k still waits on.
   int          st  [BS];
   bit [BS-1:0] dep [BS];
   bit          m_iv;
   int          m_ii;
   int          m_last;

   function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < BS; k++) begin
         st[k]  = 0;
         dep[k] = '1;
      end
      m_iv   = 0;
      m_ii   = 0;
      m_last = BS - 1;
   endtask

   function automatic int pick_state(int s);
      int c[$];
      for (int k = 0; k < BS; k++) if (st[k] == s) c.push_back(k);
      if (c.size() == 0) return -1;
      return c[$urandom_range(c.size() - 1)];
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         bit   dok, aok, ld;
         int   p, n, j;
         exp_t e;
         dok = done_valid && st[done_index] == 2;
         aok = alloc_valid && (st[alloc_index] == 0 || (dok && done_index == alloc_index));
         ld  = !m_iv || issue_ready;
         p   = -1;
         for (int i = 0; i < BS; i++) begin
`ifdef ESM_ROUND_ROBIN_EN
            j = (m_last + 1 + i) % BS;
`else
            j = i;
`endif
            if (p < 0 && st[j] == 1 && dep[j] == 0) p = j;
         end
         if (dok) begin
            st[done_index] = 0;
            for (int k = 0; k < BS; k++) dep[k][done_index] = 1'b0;
         end
         if (ld) begin
            m_iv = (p >= 0);
            if (p >= 0) begin
               m_ii   = p;
               st[p]  = 2;
               m_last = p;
            end
         end
         if (aok) begin
            st[alloc_index]               = 1;
            dep[alloc_index]              = alloc_deps;
            dep[alloc_index][alloc_index] = 1'b0;
            if (dok) dep[alloc_index][done_index] = 1'b0;
         end
         n = 0;
         for (int k = 0; k < BS; k++) if (st[k] != 0) n++;
         e.iv   = m_iv;
         e.ii   = m_ii;
         e.aerr = alloc_valid && !aok;
         e.derr = done_valid && !dok;
         e.occ  = n;
         expq.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (!rst && expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         check("issue_valid", 32'(issue_valid), 32'(e.iv));
         if (e.iv) check("issue_index", 32'(issue_index), 32'(e.ii));
         check("alloc_err", 32'(alloc_err), 32'(e.aerr));
         check("done_err", 32'(done_err), 32'(e.derr));
         check("occupancy", 32'(occupancy), 32'(e.occ));
      end
   end

   task automatic cyc(input logic av, input logic [3:0] ai, input logic [15:0] ad,
                      input logic dv, input logic [3:0] di, input logic r);
      alloc_valid = av;
      alloc_index = ai;
      alloc_deps  = ad;
      done_valid  = dv;
      done_index  = di;
      issue_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, r);
   endtask

   task automatic rand_cyc();
      logic        av, dv, r;
      logic [3:0]  ai, di;
      logic [15:0] ad;
      int          s;
      av = ($urandom % 2) == 1;
      s  = pick_state(0);
      ai = (s >= 0 && ($urandom % 4) != 0) ? 4'(s) : 4'($urandom % 16);
      ad = '0;
      for (int k = 0; k < BS; k++) if (st[k] != 0 && ($urandom % 4) == 0) ad[k] = 1'b1;
      dv = ($urandom % 2) == 1;
      s  = pick_state(2);
      di = (s >= 0 && ($urandom % 8) != 0) ? 4'(s) : 4'($urandom % 16);
      r  = ($urandom % 4) != 0;
      cyc(av, ai, ad, dv, di, r);
   endtask

   task automatic check_reset_outputs();
      check("rst_issue_valid", 32'(issue_valid), 32'd0);
      check("rst_issue_index", 32'(issue_index), 32'd0);
      check("rst_alloc_err", 32'(alloc_err), 32'd0);
      check("rst_done_err", 32'(done_err), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
   endtask

   task automatic mid_reset();
      #1 rst = 1'b1;
      expq.delete();
      #1 check_reset_outputs();
      model_reset();
      alloc_valid = 1'b0;
      done_valid  = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      model_reset();
      #12 check_reset_outputs();
      @(posedge clk);
      #1 rst = 1'b0;

      cyc(1'b1, 4'd3, 16'h0000, 1'b0, 4'd0, 1'b1);
      idle(3, 1'b1);
      cyc(1'b1, 4'd5, 16'h0008, 1'b0, 4'd0, 1'b1);
      idle(2, 1'b1);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1);
      idle(3, 1'b1);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1);
      idle(2, 1'b1);

      cyc(1'b1, 4'd2, 16'h0000, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'd7, 16'h0000, 1'b0, 4'd0, 1'b0);
      idle(4, 1'b0);
      idle(3, 1'b1);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b1);

      cyc(1'b1, 4'd4, 16'h0000, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'd4, 16'h00F0, 1'b0, 4'd0, 1'b0);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b0);
      idle(3, 1'b1);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 1'b1);

      cyc(1'b1, 4'd1, 16'h0000, 1'b0, 4'd0, 1'b1);
      idle(2, 1'b1);
      cyc(1'b1, 4'd6, 16'h0002, 1'b1, 4'd1, 1'b1);
      idle(3, 1'b1);
      cyc(1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 1'b1);
      idle(2, 1'b1);

      cyc(1'b1, 4'd1, 16'h0000, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'd8, 16'h0000, 1'b0, 4'd0, 1'b0);
      idle(2, 1'b0);
      idle(3, 1'b1);

      for (int i = 0; i < 300; i++) rand_cyc();
      mid_reset();
      for (int i = 0; i < 1500; i++) rand_cyc();
      idle(3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
